// File: rtl/j_dsp_ram_xfer.sv
// j_dsp_ram_xfer: block mover between the DSP local RAM and a pair of streams.
//   Write stream (wr_*) -> RAM, or RAM -> read stream (rd_*), one block per start.
//   Yields the local bus whenever core_req is high.
// Ports:
//   sys_clk, reset                 clock, async active-high reset
//   start, dir, start_addr, count  command (sampled when start is accepted)
//   busy, done                     status; done is a one-cycle completion pulse
//   wr_data/wr_valid/wr_ready      write stream (handshake lands the RAM write)
//   rd_data/rd_valid/rd_ready      read stream, fed from a 2-entry FIFO
//   core_req                       DSP core owns the bus this cycle
//   ram_addr, ramen, gpu_memw,
//   gpu_data_out, gpu_data_oe,
//   gpu_data_in                    local RAM bus (read data one cycle after access)
// Optional: J_DSP_RAM_XFER_ABORT_EN adds input abort and output aborted.
module j_dsp_ram_xfer #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          start,
    input  logic          dir,
    input  logic [AW-1:0] start_addr,
    input  logic [AW:0]   count,
    output logic          busy,
    output logic          done,
`ifdef J_DSP_RAM_XFER_ABORT_EN
    input  logic          abort,
    output logic          aborted,
`endif
    input  logic [DW-1:0] wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    input  logic          core_req,
    output logic [AW-1:0] ram_addr,
    output logic [1:0]    ramen,
    output logic          gpu_memw,
    output logic [DW-1:0] gpu_data_out,
    output logic          gpu_data_oe,
    input  logic [DW-1:0] gpu_data_in
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   addr_q;
    logic [CW-1:0]   remain_q;
    logic [1:0]      occ_q;
    logic            inflight_q;
    logic            wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]   fifo_q [2];

    logic            abort_c, busy_st, accept, last, pop;
    logic            wr_acc, rd_acc, acc;
    logic [2:0]      fill;

`ifdef J_DSP_RAM_XFER_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Status and stream-side decode
    assign busy_st  = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    assign busy     = busy_st;
    assign done     = (state == S_DONE);
    assign accept   = start && ((state == S_IDLE) || (state == S_DONE));
    assign last     = (remain_q == CW'(1));
    assign rd_valid = (occ_q != 2'd0);
    assign rd_data  = fifo_q[rd_ptr_q];
    assign pop      = rd_valid && rd_ready;

    // FIFO fill after this cycle's pop, counting the word still in flight.
    // Including the pop lets a read issue every cycle with rd_ready held high.
    assign fill = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

    // Access decode: the RAM write lands in the stream handshake cycle
    assign wr_ready = (state == S_WRITE) && !core_req && !abort_c;
    assign wr_acc   = wr_ready && wr_valid;
    assign rd_acc   = (state == S_READ) && !core_req && !abort_c &&
                      (remain_q != '0) && (fill < 3'd2);
    assign acc      = wr_acc || rd_acc;

    // Local bus drive; everything idles at zero when no access is issued
    assign ram_addr     = acc ? addr_q : '0;
    assign ramen        = acc ? (addr_q[AW-1] ? 2'b10 : 2'b01) : 2'b00;
    assign gpu_memw     = wr_acc;
    assign gpu_data_oe  = wr_acc;
    assign gpu_data_out = wr_acc ? wr_data : '0;

    // State register
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; DONE accepts a new command since busy is already low
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (count == '0) state_nxt = S_DONE;
                    else             state_nxt = dir ? S_READ : S_WRITE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_WRITE: begin
                if (abort_c)              state_nxt = S_DONE;
                else if (wr_acc && last)  state_nxt = S_DONE;
            end
            S_READ: begin
                if (abort_c)              state_nxt = S_DONE;
                else if (rd_acc && last)  state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort_c)              state_nxt = S_DONE;
                else if (fill == 3'd0)    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address/count and read FIFO
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            remain_q   <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            if (accept) begin
                addr_q   <= start_addr;
                remain_q <= count;
            end else if (acc) begin
                addr_q   <= addr_q + AW'(1);
                remain_q <= remain_q - CW'(1);
            end
            if (abort_c && busy_st) begin
                // Abort drops queued words and any return still in flight
                occ_q      <= 2'd0;
                inflight_q <= 1'b0;
                wr_ptr_q   <= 1'b0;
                rd_ptr_q   <= 1'b0;
            end else begin
                inflight_q <= rd_acc;
                if (inflight_q) begin
                    fifo_q[wr_ptr_q] <= gpu_data_in;
                    wr_ptr_q         <= ~wr_ptr_q;
                end
                if (pop) rd_ptr_q <= ~rd_ptr_q;
                occ_q <= fill[1:0];
            end
        end
    end

`ifdef J_DSP_RAM_XFER_ABORT_EN
    // Remembers that the transfer ending in this DONE cycle was aborted
    logic abort_flag_q;
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) abort_flag_q <= 1'b0;
        else       abort_flag_q <= abort_c && busy_st;
    end
    assign aborted = done && abort_flag_q;
`endif

endmodule

// File: tb/tb_j_dsp_ram_xfer.sv
// Directed bench for j_dsp_ram_xfer with a small local-RAM model.
module tb_j_dsp_ram_xfer;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic          sys_clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          dir = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   count = '0;
    logic          busy, done;
    logic [DW-1:0] wr_data = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic          core_req = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ramen;
    logic          gpu_memw;
    logic [DW-1:0] gpu_data_out;
    logic          gpu_data_oe;
    logic [DW-1:0] gpu_data_in = '0;
`ifdef J_DSP_RAM_XFER_ABORT_EN
    logic          abort = 1'b0;
    logic          aborted;
`endif

    logic [31:0] mem [1024];
    int n_checks = 0;
    int n_errors = 0;

    j_dsp_ram_xfer #(.AW(AW), .DW(DW)) dut (
        .sys_clk(sys_clk), .reset(reset),
        .start(start), .dir(dir), .start_addr(start_addr), .count(count),
        .busy(busy), .done(done),
`ifdef J_DSP_RAM_XFER_ABORT_EN
        .abort(abort), .aborted(aborted),
`endif
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .core_req(core_req),
        .ram_addr(ram_addr), .ramen(ramen), .gpu_memw(gpu_memw),
        .gpu_data_out(gpu_data_out), .gpu_data_oe(gpu_data_oe),
        .gpu_data_in(gpu_data_in)
    );

    always #5 sys_clk = ~sys_clk;

    // Local RAM model: preloaded with mem[N] = N during reset, read data one cycle late
    always @(posedge sys_clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[10'(i)] = 32'(i);
        end else if (ramen != 2'b00 && gpu_memw) begin
            mem[ram_addr] = gpu_data_out;
        end
        gpu_data_in <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] bank(input int a);
        return ((a % 1024) >= 512) ? 2'b10 : 2'b01;
    endfunction

    task automatic tick;
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic run_write(input int a, input int n);
        logic [31:0] d;
        start = 1'b1; dir = 1'b0; start_addr = 10'(a); count = 11'(n); wr_valid = 1'b0;
        tick;
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            d = 32'h1111_1111 * 32'(i + 1);
            wr_valid = 1'b1; wr_data = d;
            #1;
            check("wr_memw", 32'(gpu_memw), 32'd1);
            check("wr_oe", 32'(gpu_data_oe), 32'd1);
            check("wr_addr", 32'(ram_addr), 32'((a + i) % 1024));
            check("wr_bank", 32'(ramen), 32'(bank(a + i)));
            check("wr_data", gpu_data_out, d);
            tick;
        end
        wr_valid = 1'b0;
        #1;
        check("wr_done", 32'(done), 32'd1);
        check("wr_done_busy", 32'(busy), 32'd0);
        check("wr_done_bus", 32'(ramen), 32'd0);
        tick;
        check("wr_done_pulse", 32'(done), 32'd0);
    endtask

    task automatic run_read(input int a, input int n, input bit toggle, input int cr_at);
        int issued = 0;
        int delivered = 0;
        int cyc = 0;
        bit seen_done = 1'b0;
        start = 1'b1; dir = 1'b1; start_addr = 10'(a); count = 11'(n);
        tick;
        start = 1'b0;
        while (!seen_done && cyc < 200) begin
            rd_ready = (toggle && (cyc % 2) != 0) ? 1'b0 : 1'b1;
            core_req = (cyc >= cr_at && cyc < cr_at + 3);
            #1;
            if (done) begin
                seen_done = 1'b1;
            end else begin
                if (core_req) begin
                    check("arb_no_access", 32'(ramen), 32'd0);
                end else if (ramen != 2'b00) begin
                    check("rd_addr", 32'(ram_addr), 32'((a + issued) % 1024));
                    check("rd_bank", 32'(ramen), 32'(bank(a + issued)));
                    check("rd_memw", 32'(gpu_memw), 32'd0);
                    issued++;
                end
                if (rd_valid) begin
                    check("rd_data", rd_data, 32'((a + delivered) % 1024));
                    if (rd_ready) delivered++;
                end
            end
            tick;
            cyc++;
        end
        rd_ready = 1'b0; core_req = 1'b0;
        check("rd_done_seen", 32'(seen_done), 32'd1);
        check("rd_issued", 32'(issued), 32'(n));
        check("rd_delivered", 32'(delivered), 32'(n));
        check("rd_done_pulse", 32'(done), 32'd0);
        check("rd_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        tick; tick;
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_ramen", 32'(ramen), 32'd0);
        check("rst_memw", 32'(gpu_memw), 32'd0);
        check("rst_oe", 32'(gpu_data_oe), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        tick;

        // Write block at 10..13
        run_write(10, 4);
        check("mem_10", mem[10'd10], 32'h1111_1111);
        check("mem_13", mem[10'd13], 32'h4444_4444);

        // Wrap-around 1022, 1023, 0
        run_write(1022, 3);
        check("mem_1022", mem[10'd1022], 32'h1111_1111);
        check("mem_1023", mem[10'd1023], 32'h2222_2222);
        check("mem_0", mem[10'd0], 32'h3333_3333);

        // Zero count: done next cycle, no bus activity
        start = 1'b1; dir = 1'b0; start_addr = 10'd5; count = 11'd0;
        #1;
        check("zero_bus0", 32'(ramen), 32'd0);
        tick;
        start = 1'b0;
        #1;
        check("zero_done", 32'(done), 32'd1);
        check("zero_bus1", 32'(ramen), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        tick;
        check("zero_done_pulse", 32'(done), 32'd0);

        // Read across the bank boundary with toggling backpressure
        run_read(508, 8, 1'b1, 1000);

        // Read with the core claiming the bus for 3 cycles mid-block
        run_read(100, 8, 1'b0, 3);

        // Reset three words into a 16-word write
        start = 1'b1; dir = 1'b0; start_addr = 10'd200; count = 11'd16;
        tick;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = 32'(i);
            tick;
        end
        check("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_ramen", 32'(ramen), 32'd0);
        check("mid_memw", 32'(gpu_memw), 32'd0);
        check("mid_wr_ready", 32'(wr_ready), 32'd0);
        tick;
        reset = 1'b0; wr_valid = 1'b0;
        tick;
        run_write(300, 2);
        check("mem_300", mem[10'd300], 32'h1111_1111);
        check("mem_301", mem[10'd301], 32'h2222_2222);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
